// File: rtl/register_file_pipelined_if.sv
// Bus bundle for register_file_pipelined.
// master: the requester. It drives the write/read ports and clear, and receives the read data,
//         the valid flags, busy and conflict.
// slave:  the register file itself.
// Ports (packed per-port arrays):
//   write/address_write/data_in/byte_enable : write ports, index N_WRITE-1 has highest priority
//   read/address_read                       : read requests
//   data_out/valid_out                      : read results
//   clear/busy/conflict                     : bulk-clear command, clear active, address collision
interface register_file_pipelined_if #(
  parameter int unsigned N_BIT_DATA    = 32,
  parameter int unsigned N_BIT_ADDRESS = 5,
  parameter int unsigned N_WRITE       = 2,
  parameter int unsigned N_READ        = 4
);
  localparam int unsigned NBytes = N_BIT_DATA / 8;

  logic [N_WRITE-1:0]                    write;
  logic [N_WRITE-1:0][N_BIT_ADDRESS-1:0] address_write;
  logic [N_WRITE-1:0][N_BIT_DATA-1:0]    data_in;
  logic [N_WRITE-1:0][NBytes-1:0]        byte_enable;
  logic [N_READ-1:0]                     read;
  logic [N_READ-1:0][N_BIT_ADDRESS-1:0]  address_read;
  logic [N_READ-1:0][N_BIT_DATA-1:0]     data_out;
  logic [N_READ-1:0]                     valid_out;
  logic                                  clear;
  logic                                  busy;
  logic                                  conflict;

  modport master (
    output write, address_write, data_in, byte_enable, read, address_read, clear,
    input  data_out, valid_out, busy, conflict
  );

  modport slave (
    input  write, address_write, data_in, byte_enable, read, address_read, clear,
    output data_out, valid_out, busy, conflict
  );
endinterface

// File: rtl/register_file_pipelined.sv
// Multi-port register file with byte-enabled prioritised writes, optional write-to-read
// forwarding, selectable read latency (0/1) and a one-entry-per-cycle bulk clear engine.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset; zeroes the array and aborts any clear
//   bus     : register_file_pipelined_if slave modport (write/read ports, clear, busy, conflict)
module register_file_pipelined #(
  parameter int unsigned N_BIT_DATA    = 32,
  parameter int unsigned N_BIT_ADDRESS = 5,
  parameter int unsigned N_WRITE       = 2,
  parameter int unsigned N_READ        = 4,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned BYPASS        = 1
) (
  input logic                      clock,
  input logic                      reset_n,
  register_file_pipelined_if.slave bus
);
  localparam int unsigned NCells = 2 ** N_BIT_ADDRESS;
  localparam int unsigned NBytes = N_BIT_DATA / 8;

  typedef enum logic {StIdle, StClear} state_e;

  state_e                   state_q, state_d;
  logic [N_BIT_ADDRESS-1:0] ptr_q, ptr_d;
  logic                     conflict_q, conflict_d;
  logic [N_BIT_DATA-1:0]    mem_q [NCells];
  logic [N_BIT_DATA-1:0]    mem_d [NCells];
  logic                     busy;

  assign busy = (state_q == StClear);

  // Clear engine: walk the pointer across every entry, then drop back to idle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (bus.clear) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      StClear: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Next array contents. Ascending port order lets the highest index win each byte lane.
  always_comb begin
    mem_d = mem_q;
    if (busy) begin
      mem_d[ptr_q] = '0;
    end else begin
      for (int unsigned j = 0; j < N_WRITE; j++) begin
        for (int unsigned b = 0; b < NBytes; b++) begin
          if (bus.write[j] && bus.byte_enable[j][b]) begin
            mem_d[bus.address_write[j]][b*8 +: 8] = bus.data_in[j][b*8 +: 8];
          end
        end
      end
    end
  end

  // Any two active write ports on the same entry collide, regardless of byte enables.
  always_comb begin
    conflict_d = 1'b0;
    if (!busy) begin
      for (int unsigned j = 0; j < N_WRITE; j++) begin
        for (int unsigned k = j + 1; k < N_WRITE; k++) begin
          if (bus.write[j] && bus.write[k] && (bus.address_write[j] == bus.address_write[k])) begin
            conflict_d = 1'b1;
          end
        end
      end
    end
  end

  // Read values. While idle, mem_d is mem_q overlaid with this cycle's writes, which is
  // exactly the forwarded view. Gating by reset_n keeps combinational reads at 0 in reset.
  logic [N_READ-1:0][N_BIT_DATA-1:0] rd_data_d;
  logic [N_READ-1:0]                 rd_valid_d;

  always_comb begin
    for (int unsigned i = 0; i < N_READ; i++) begin
      rd_valid_d[i] = bus.read[i] && !busy && reset_n;
      rd_data_d[i]  = '0;
      if (rd_valid_d[i]) begin
        rd_data_d[i] = (BYPASS != 0) ? mem_d[bus.address_read[i]] : mem_q[bus.address_read[i]];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      conflict_q <= 1'b0;
      for (int unsigned k = 0; k < NCells; k++) mem_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      conflict_q <= conflict_d;
      for (int unsigned k = 0; k < NCells; k++) mem_q[k] <= mem_d[k];
    end
  end

  if (READ_LATENCY == 0) begin : g_rd_comb
    assign bus.data_out  = rd_data_d;
    assign bus.valid_out = rd_valid_d;
  end else begin : g_rd_reg
    logic [N_READ-1:0][N_BIT_DATA-1:0] rd_data_q;
    logic [N_READ-1:0]                 rd_valid_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= '0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign bus.data_out  = rd_data_q;
    assign bus.valid_out = rd_valid_q;
  end

  assign bus.busy     = busy;
  assign bus.conflict = conflict_q;
endmodule

// File: tb/tb_register_file_pipelined.sv
// Self-checking bench for register_file_pipelined: directed scenarios plus random traffic,
// all compared against a behavioural model of the register file.
module tb_register_file_pipelined;
  parameter int unsigned DW = 32;
  parameter int unsigned AW = 3;
  parameter int unsigned NW = 2;
  parameter int unsigned NR = 4;
  parameter int unsigned RL = 1;
  parameter int unsigned BP = 1;
  localparam int unsigned NC = 1 << AW;
  localparam int unsigned NB = DW / 8;

  logic clock;
  logic reset_n;

  register_file_pipelined_if #(
    .N_BIT_DATA(DW), .N_BIT_ADDRESS(AW), .N_WRITE(NW), .N_READ(NR)
  ) bus ();

  register_file_pipelined #(
    .N_BIT_DATA(DW), .N_BIT_ADDRESS(AW), .N_WRITE(NW), .N_READ(NR),
    .READ_LATENCY(RL), .BYPASS(BP)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total;
  int bad;

  // Reference model: array contents, remaining clear cycles, pending conflict flag and the
  // read results captured at the previous edge.
  logic [DW-1:0] m_mem [NC];
  int            clr_left;
  logic          m_conflict;
  logic [DW-1:0] m_prev_d [NR];
  logic          m_prev_v [NR];

  function automatic logic [DW-1:0] lane_mask(input logic [NB-1:0] be);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++) if (be[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Entry value with every write port targeting it applied, lowest port first.
  function automatic logic [DW-1:0] overlay(input logic [DW-1:0] base, input logic [AW-1:0] a);
    logic [DW-1:0] v;
    logic [DW-1:0] mk;
    v = base;
    for (int j = 0; j < NW; j++) begin
      if (bus.write[j] && bus.address_write[j] == a) begin
        mk = lane_mask(bus.byte_enable[j]);
        v  = (v & ~mk) | (bus.data_in[j] & mk);
      end
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < NC; a++) m_mem[a] = '0;
    clr_left   = 0;
    m_conflict = 1'b0;
    for (int i = 0; i < NR; i++) begin
      m_prev_d[i] = '0;
      m_prev_v[i] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    bus.write         = '0;
    bus.address_write = '0;
    bus.data_in       = '0;
    bus.byte_enable   = '0;
    bus.read          = '0;
    bus.address_read  = '0;
    bus.clear         = 1'b0;
  endtask

  // One clock: check outputs against the model mid-cycle, advance the model, cross the edge.
  task automatic do_cycle();
    logic [DW-1:0] now_d [NR];
    logic          now_v [NR];
    logic [DW-1:0] exp_d;
    logic          exp_v;
    logic          busy_m;
    logic          conf_next;
    logic [AW-1:0] ra;
    #1;
    busy_m = (clr_left > 0);
    for (int i = 0; i < NR; i++) begin
      ra       = bus.address_read[i];
      now_v[i] = bus.read[i] && !busy_m;
      now_d[i] = '0;
      if (now_v[i]) now_d[i] = (BP != 0) ? overlay(m_mem[ra], ra) : m_mem[ra];
    end
    total++;
    if (bus.busy !== busy_m) begin
      bad++;
      $display("FAIL busy t=%0t got %b want %b", $time, bus.busy, busy_m);
    end
    total++;
    if (bus.conflict !== m_conflict) begin
      bad++;
      $display("FAIL conflict t=%0t got %b want %b", $time, bus.conflict, m_conflict);
    end
    for (int i = 0; i < NR; i++) begin
      exp_d = (RL == 0) ? now_d[i] : m_prev_d[i];
      exp_v = (RL == 0) ? now_v[i] : m_prev_v[i];
      total++;
      if (bus.data_out[i] !== exp_d) begin
        bad++;
        $display("FAIL data_out[%0d] t=%0t got %h want %h", i, $time, bus.data_out[i], exp_d);
      end
      total++;
      if (bus.valid_out[i] !== exp_v) begin
        bad++;
        $display("FAIL valid_out[%0d] t=%0t got %b want %b", i, $time, bus.valid_out[i], exp_v);
      end
    end
    conf_next = 1'b0;
    if (!busy_m) begin
      for (int j = 0; j < NW; j++)
        for (int k = j + 1; k < NW; k++)
          if (bus.write[j] && bus.write[k] && bus.address_write[j] == bus.address_write[k])
            conf_next = 1'b1;
    end
    if (busy_m) begin
      m_mem[NC - clr_left] = '0;
      clr_left--;
    end else begin
      for (int a = 0; a < NC; a++) m_mem[a] = overlay(m_mem[a], AW'(a));
      if (bus.clear) clr_left = NC;
    end
    m_conflict = conf_next;
    @(posedge clock);
    #1;
    for (int i = 0; i < NR; i++) begin
      m_prev_d[i] = now_d[i];
      m_prev_v[i] = now_v[i];
    end
  endtask

  // Asynchronous reset with reads requested: every output must drop to 0 immediately.
  task automatic apply_reset();
    bus.read = '1;
    reset_n  = 1'b0;
    #1;
    model_reset();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got %b want 0", bus.busy);
    end
    total++;
    if (bus.conflict !== 1'b0) begin
      bad++;
      $display("FAIL reset_conflict got %b want 0", bus.conflict);
    end
    for (int i = 0; i < NR; i++) begin
      total++;
      if (bus.data_out[i] !== '0 || bus.valid_out[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_out[%0d] got %h/%b want 0/0", i, bus.data_out[i], bus.valid_out[i]);
      end
    end
    #2;
    reset_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_reset();
    apply_reset();
    for (int a = 0; a < NC; a++) begin
      bus.read[0]         = 1'b1;
      bus.address_read[0] = AW'(a);
      do_cycle();
      total++;
      if (bus.data_out[0] !== '0 || bus.valid_out[0] !== 1'b1) begin
        bad++;
        $display("FAIL reset_read a=%0d got %h/%b want 0/1", a, bus.data_out[0],
                 bus.valid_out[0]);
      end
    end
    idle_inputs();
    do_cycle();
    total++;
    if (bus.data_out[0] !== '0 || bus.valid_out[0] !== 1'b0) begin
      bad++;
      $display("FAIL no_read got %h/%b want 0/0", bus.data_out[0], bus.valid_out[0]);
    end
  endtask

  task automatic test_byte_priority();
    logic [DW-1:0] want;
    want = DW'(32'h1122CCDD);
    bus.write            = '0;
    bus.write[0]         = 1'b1;
    bus.address_write[0] = AW'(5);
    bus.data_in[0]       = DW'(32'h11223344);
    bus.byte_enable[0]   = '1;
    bus.write[1]         = 1'b1;
    bus.address_write[1] = AW'(5);
    bus.data_in[1]       = DW'(32'hAABBCCDD);
    bus.byte_enable[1]   = NB'(4'b0011);
    do_cycle();
    total++;
    if (bus.conflict !== 1'b1) begin
      bad++;
      $display("FAIL conflict_set got %b want 1", bus.conflict);
    end
    idle_inputs();
    bus.read[1]         = 1'b1;
    bus.address_read[1] = AW'(5);
    do_cycle();
    total++;
    if (bus.conflict !== 1'b0) begin
      bad++;
      $display("FAIL conflict_one_cycle got %b want 0", bus.conflict);
    end
    total++;
    if (bus.data_out[1] !== want) begin
      bad++;
      $display("FAIL priority_merge got %h want %h", bus.data_out[1], want);
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    logic [DW-1:0] dead;
    logic [DW-1:0] want;
    dead = DW'(32'hDEADBEEF);
    want = (RL == 0 || BP != 0) ? dead : '0;
    bus.write[0]         = 1'b1;
    bus.address_write[0] = AW'(2);
    bus.data_in[0]       = '0;
    bus.byte_enable[0]   = '1;
    do_cycle();
    bus.data_in[0]      = dead;
    bus.read[0]         = 1'b1;
    bus.address_read[0] = AW'(2);
    do_cycle();
    total++;
    if (bus.data_out[0] !== want) begin
      bad++;
      $display("FAIL bypass_same_cycle got %h want %h", bus.data_out[0], want);
    end
    bus.write = '0;
    do_cycle();
    total++;
    if (bus.data_out[0] !== dead) begin
      bad++;
      $display("FAIL bypass_next_read got %h want %h", bus.data_out[0], dead);
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int busy_cnt;
    for (int a = 0; a < NC; a++) begin
      bus.write[0]         = 1'b1;
      bus.address_write[0] = AW'(a);
      bus.data_in[0]       = '1;
      bus.byte_enable[0]   = '1;
      do_cycle();
    end
    idle_inputs();
    do_cycle();
    bus.clear = 1'b1;
    do_cycle();
    busy_cnt = 0;
    if (bus.busy === 1'b1) busy_cnt++;
    for (int k = 1; k <= NC; k++) begin
      idle_inputs();
      bus.read[0]         = 1'b1;
      bus.address_read[0] = AW'(k % NC);
      if (k == 2) bus.clear = 1'b1;
      if (k == 3) begin
        bus.write[0]         = 1'b1;
        bus.address_write[0] = AW'(NC - 1);
        bus.data_in[0]       = '1;
        bus.byte_enable[0]   = '1;
      end
      do_cycle();
      if (bus.busy === 1'b1) busy_cnt++;
      if (k == 4) begin
        total++;
        if (bus.valid_out[0] !== 1'b0) begin
          bad++;
          $display("FAIL read_while_busy got %b want 0", bus.valid_out[0]);
        end
      end
    end
    total++;
    if (busy_cnt != NC) begin
      bad++;
      $display("FAIL busy_length got %0d want %0d", busy_cnt, NC);
    end
    idle_inputs();
    for (int a = 0; a < NC; a++) begin
      bus.read[2]         = 1'b1;
      bus.address_read[2] = AW'(a);
      do_cycle();
      total++;
      if (bus.data_out[2] !== '0 || bus.valid_out[2] !== 1'b1) begin
        bad++;
        $display("FAIL cleared a=%0d got %h/%b want 0/1", a, bus.data_out[2], bus.valid_out[2]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    bus.clear = 1'b1;
    do_cycle();
    bus.clear = 1'b0;
    for (int k = 1; k <= 3; k++) do_cycle();
    apply_reset();
    bus.clear = 1'b1;
    do_cycle();
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL clear_after_reset got %b want 1", bus.busy);
    end
    bus.clear = 1'b0;
    for (int k = 0; k < NC + 1; k++) do_cycle();
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int j = 0; j < NW; j++) begin
        bus.write[j]         = ($urandom_range(0, 1) == 1);
        bus.address_write[j] = AW'($urandom_range(0, 1) == 1 ? $urandom_range(0, 1)
                                                             : $urandom_range(0, NC - 1));
        bus.data_in[j]       = DW'($urandom);
        bus.byte_enable[j]   = NB'($urandom);
      end
      for (int i = 0; i < NR; i++) begin
        bus.read[i]         = ($urandom_range(0, 3) != 0);
        bus.address_read[i] = AW'($urandom_range(0, NC - 1));
      end
      bus.clear = ($urandom_range(0, 39) == 0);
      do_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clock);
    #1;
    test_reset();
    test_byte_priority();
    test_bypass();
    test_clear();
    test_reset_mid_clear();
    test_random(400);
    apply_reset();
    test_random(200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
